// File: rtl/cpu_trace_buffer.sv
// Circular trace buffer for the multicycle CPU: captures per-cycle state, freezes on
// a PC trigger (plus post window) or cycle limit, then drains oldest-first. Optional: TRACE_CYCLE_LIMIT_EN.
module cpu_trace_buffer #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 8,
    parameter int MAX_CYCLES = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    sample_en,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic [DATA_W-1:0]       alu_in,
    input  logic [6:0]              opcode_in,
    input  logic [4:0]              estado_in,
    input  logic [2:0]              flags_in,
    input  logic                    trig_en,
    input  logic [DATA_W-1:0]       trig_pc,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [2*DATA_W+14:0]    rd_data,
    output logic                    rd_last,
    output logic [2:0]              state,
    output logic                    triggered,
    output logic                    done,
    output logic                    halt,
    output logic [$clog2(DEPTH):0]  fill_count
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 2*DATA_W + 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_PRE = 3'd1, S_POST = 3'd2, S_DONE = 3'd3, S_READ = 3'd4
    } state_t;

    state_t             st;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt, oldest;
    logic [AW:0]        rd_rem;
    logic               capturing, wr_en, trig_hit, limit_hit;

    assign state     = st;
    assign done      = (st == S_DONE) || (st == S_READ);
    assign capturing = (st == S_PRE) || (st == S_POST);
    assign wr_en     = capturing && sample_en;
    assign trig_hit  = (st == S_PRE) && sample_en && trig_en && (pc_in == trig_pc);
    assign oldest    = wr_ptr - fill_count[AW-1:0];

`ifdef TRACE_CYCLE_LIMIT_EN
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    logic [CW-1:0] cycle_cnt;
    logic          halt_q;

    assign limit_hit = capturing && (cycle_cnt == CW'(MAX_CYCLES - 1));
    assign halt      = halt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            halt_q    <= 1'b0;
        end else if (st == S_IDLE && arm) begin
            cycle_cnt <= '0;
            halt_q    <= 1'b0;
        end else if (capturing) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (limit_hit) halt_q <= 1'b1;
        end
    end
`else
    assign limit_hit = 1'b0;
    assign halt      = 1'b0;
`endif

    // Trace RAM is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= {flags_in, estado_in, opcode_in, alu_in, pc_in};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st         <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_cnt   <= '0;
            rd_rem     <= '0;
            fill_count <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (arm) begin
                    st         <= S_PRE;
                    wr_ptr     <= '0;
                    fill_count <= '0;
                    post_cnt   <= '0;
                    triggered  <= 1'b0;
                end
                S_PRE, S_POST: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill_count != (AW+1)'(DEPTH)) fill_count <= fill_count + 1'b1;
                    end
                    if (st == S_PRE && trig_hit) begin
                        triggered <= 1'b1;
                        if (POST_TRIG == 0) st <= S_DONE;
                        else begin
                            st       <= S_POST;
                            post_cnt <= AW'(POST_TRIG);
                        end
                    end
                    if (st == S_POST && sample_en) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) st <= S_DONE;
                    end
                    // Cycle limit overrides any window still open.
                    if (limit_hit) st <= S_DONE;
                end
                S_DONE: begin
                    rd_data <= mem[oldest];
                    rd_ptr  <= oldest + 1'b1;
                    rd_rem  <= fill_count;
                    if (fill_count == '0) st <= S_IDLE;
                    else begin
                        st       <= S_READ;
                        rd_valid <= 1'b1;
                        rd_last  <= (fill_count == (AW+1)'(1));
                    end
                end
                S_READ: if (rd_ready) begin
                    if (rd_rem == (AW+1)'(1)) begin
                        st       <= S_IDLE;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end else begin
                        rd_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        rd_rem  <= rd_rem - 1'b1;
                        rd_last <= (rd_rem == (AW+1)'(2));
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: default instance plus a POST_TRIG=0 instance.
module tb_cpu_trace_buffer;
    localparam int DATA_W  = 64;
    localparam int ENTRY_W = 2*DATA_W + 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic arm = 1'b0, arm0 = 1'b0, sample_en = 1'b0, trig_en = 1'b0;
    logic rd_ready = 1'b0, rdy0 = 1'b0;
    logic [DATA_W-1:0] pc_in = '0, alu_in = '0, trig_pc = '0;
    logic [6:0] opcode_in = '0;
    logic [4:0] estado_in = '0;
    logic [2:0] flags_in = '0;

    logic rd_valid, rd_last, triggered, done, halt;
    logic [ENTRY_W-1:0] rd_data;
    logic [2:0] state;
    logic [4:0] fill_count;
    logic v0, l0, trg0, dn0, h0;
    logic [ENTRY_W-1:0] d0;
    logic [2:0] st0;
    logic [4:0] fc0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cpu_trace_buffer #(.DATA_W(64), .DEPTH(16), .POST_TRIG(8), .MAX_CYCLES(30)) dut (
        .clock(clock), .reset(reset), .arm(arm), .sample_en(sample_en),
        .pc_in(pc_in), .alu_in(alu_in), .opcode_in(opcode_in), .estado_in(estado_in),
        .flags_in(flags_in), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state(state), .triggered(triggered), .done(done), .halt(halt), .fill_count(fill_count));

    cpu_trace_buffer #(.DATA_W(64), .DEPTH(16), .POST_TRIG(0), .MAX_CYCLES(30)) dut0 (
        .clock(clock), .reset(reset), .arm(arm0), .sample_en(sample_en),
        .pc_in(pc_in), .alu_in(alu_in), .opcode_in(opcode_in), .estado_in(estado_in),
        .flags_in(flags_in), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(v0), .rd_ready(rdy0), .rd_data(d0), .rd_last(l0),
        .state(st0), .triggered(trg0), .done(dn0), .halt(h0), .fill_count(fc0));

    // Expected entry for sample k: {flags, estado, opcode, alu, pc}.
    function automatic logic [ENTRY_W-1:0] entry(int k);
        logic [31:0] kk;
        logic [DATA_W-1:0] pc;
        kk = k;
        pc = DATA_W'(4 * k);
        return {kk[2:0], kk[4:0], kk[6:0], pc ^ 64'hA5A5_0000_FFFF_1234, pc};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(int k);
        logic [ENTRY_W-1:0] e;
        e = entry(k);
        pc_in     = e[DATA_W-1:0];
        alu_in    = e[2*DATA_W-1:DATA_W];
        opcode_in = e[2*DATA_W+6:2*DATA_W];
        estado_in = e[2*DATA_W+11:2*DATA_W+7];
        flags_in  = e[2*DATA_W+14:2*DATA_W+12];
    endtask

    // Arm the main instance and run samples 0..24 (trigger at PC 0x40 = sample 16) into READ.
    task automatic capture_trig();
        trig_en = 1'b1; trig_pc = 64'h40;
        arm = 1'b1; step(); arm = 1'b0;
        sample_en = 1'b1;
        for (int k = 0; k <= 24; k++) begin drive(k); step(); end
        sample_en = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (state !== 3'd0 || st0 !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d/%0d exp 0", state, st0); end
        n_tests++; if ({rd_valid, rd_last, triggered, done, halt} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 00000", {rd_valid, rd_last, triggered, done, halt}); end
        n_tests++; if (rd_data !== '0 || fill_count !== 5'd0) begin n_fail++; $display("FAIL reset_data: got %0h fc %0d exp 0", rd_data, fill_count); end
        step(); reset = 1'b1; step();
    endtask

    task automatic test_trigger_window();
        trig_en = 1'b1; trig_pc = 64'h40;
        arm = 1'b1; step(); arm = 1'b0;
        n_tests++; if (state !== 3'd1 || fill_count !== 5'd0) begin n_fail++; $display("FAIL arm_pre: got st %0d fc %0d exp 1 0", state, fill_count); end
        sample_en = 1'b1;
        for (int k = 0; k <= 16; k++) begin drive(k); step(); end
        n_tests++; if (state !== 3'd2 || triggered !== 1'b1) begin n_fail++; $display("FAIL trig_post: got st %0d trg %b exp 2 1", state, triggered); end
        for (int k = 17; k <= 24; k++) begin drive(k); step(); end
        sample_en = 1'b0;
        n_tests++; if (state !== 3'd3 || done !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL done_timing: got st %0d done %b v %b exp 3 1 0", state, done, rd_valid); end
        step();
        n_tests++; if (state !== 3'd4 || rd_valid !== 1'b1 || fill_count !== 5'd16) begin n_fail++; $display("FAIL read_entry: got st %0d v %b fc %0d exp 4 1 16", state, rd_valid, fill_count); end
        rd_ready = 1'b1;
        // 25 samples into 16 entries: oldest surviving is sample 9 (PC 0x24), newest sample 24 (PC 0x60).
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (rd_data !== entry(9 + i) || rd_last !== (i == 15)) begin n_fail++; $display("FAIL read_%0d: got %0h last %b exp %0h last %b", i, rd_data, rd_last, entry(9 + i), (i == 15)); end
            step();
        end
        rd_ready = 1'b0;
        n_tests++; if (state !== 3'd0 || rd_valid !== 1'b0 || triggered !== 1'b1 || halt !== 1'b0) begin n_fail++; $display("FAIL read_end: got st %0d v %b trg %b halt %b exp 0 0 1 0", state, rd_valid, triggered, halt); end
    endtask

    task automatic test_post_zero();
        trig_en = 1'b1; trig_pc = 64'h08;
        arm0 = 1'b1; step(); arm0 = 1'b0;
        sample_en = 1'b1;
        for (int k = 0; k <= 2; k++) begin drive(k); step(); end
        sample_en = 1'b0;
        n_tests++; if (st0 !== 3'd3 || trg0 !== 1'b1) begin n_fail++; $display("FAIL p0_done: got st %0d trg %b exp 3 1", st0, trg0); end
        step();
        n_tests++; if (st0 !== 3'd4 || fc0 !== 5'd3) begin n_fail++; $display("FAIL p0_read: got st %0d fc %0d exp 4 3", st0, fc0); end
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (v0 !== 1'b1 || d0 !== entry(i) || l0 !== (i == 2)) begin n_fail++; $display("FAIL p0_entry_%0d: got v %b %0h last %b exp %0h", i, v0, d0, l0, entry(i)); end
            step();
        end
        rdy0 = 1'b0;
        n_tests++; if (st0 !== 3'd0 || v0 !== 1'b0) begin n_fail++; $display("FAIL p0_idle: got st %0d v %b exp 0 0", st0, v0); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int cyc = 0;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        capture_trig();
        while (rd_valid === 1'b1 && cyc < 200) begin
            rd_ready = pat[cyc % 4];
            n_tests++; if (rd_data !== entry(9 + idx)) begin n_fail++; $display("FAIL stall_%0d: got %0h exp %0h", cyc, rd_data, entry(9 + idx)); end
            step();
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        n_tests++; if (idx !== 16 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_count: got %0d v %b exp 16 0", idx, rd_valid); end
    endtask

    task automatic test_reset_mid_read();
        capture_trig();
        rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_tests++; if (rd_valid !== 1'b0 || state !== 3'd0 || rd_data !== '0 || triggered !== 1'b0) begin n_fail++; $display("FAIL async_reset: got v %b st %0d trg %b exp 0 0 0", rd_valid, state, triggered); end
        step(); reset = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        n_tests++; if (state !== 3'd1 || fill_count !== 5'd0) begin n_fail++; $display("FAIL rearm: got st %0d fc %0d exp 1 0", state, fill_count); end
    endtask

    task automatic test_cycle_limit();
        reset = 1'b0; step(); reset = 1'b1;
        trig_en = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        sample_en = 1'b1;
        for (int k = 0; k < 30; k++) begin drive(k); step(); end
`ifdef TRACE_CYCLE_LIMIT_EN
        sample_en = 1'b0;
        n_tests++; if (state !== 3'd3 || halt !== 1'b1 || fill_count !== 5'd16 || triggered !== 1'b0) begin n_fail++; $display("FAIL limit_done: got st %0d halt %b fc %0d exp 3 1 16", state, halt, fill_count); end
        step();
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (rd_data !== entry(14 + i)) begin n_fail++; $display("FAIL limit_read_%0d: got %0h exp %0h", i, rd_data, entry(14 + i)); end
            step();
        end
        rd_ready = 1'b0;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL limit_idle: got %0d exp 0", state); end
`else
        for (int k = 30; k < 40; k++) begin drive(k); step(); end
        sample_en = 1'b0;
        n_tests++; if (state !== 3'd1 || halt !== 1'b0 || fill_count !== 5'd16 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL nolimit: got st %0d halt %b fc %0d exp 1 0 16", state, halt, fill_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_trigger_window();
        test_post_zero();
        test_back_to_back();
        test_reset_mid_read();
        test_cycle_limit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
